// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters using an active-low request/grant handshake.
// Inputs are registered before arbitration; all outputs come straight from flops.
module bus_arbiter #(
    parameter int MASTERS    = 4,
    parameter int HOLD_LIMIT = 16
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic [MASTERS-1:0] busReq_,
    input  logic               busAs_,
    output logic [MASTERS-1:0] busGrnt_,
    output logic [1:0]         busOwner,
    output logic               ownerValid
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [MASTERS-1:0] ONE_HOT0 = MASTERS'(1);
    localparam logic [7:0]         LIMIT    = 8'(HOLD_LIMIT);

    state_t             state_q, state_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         owner_q, owner_d;
    logic [7:0]         hold_q, hold_d;
    logic [MASTERS-1:0] grnt_q, grnt_d;
    logic [MASTERS-1:0] req_q;
    logic               as_idle_q;

    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       others;
    logic       release_own;
    logic       preempt;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            owner_q   <= 2'd0;
            hold_q    <= 8'd0;
            grnt_q    <= '1;
            req_q     <= '0;
            as_idle_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            grnt_q    <= grnt_d;
            req_q     <= ~busReq_;
            as_idle_q <= busAs_;
        end
    end

    // The current owner (== last) is only eligible at the tail of the search when idle.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = last_q + 2'(k);
            if (!found && req_q[idx] && (k < MASTERS || state_q == IDLE)) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign others      = |(req_q & ~(ONE_HOT0 << last_q));
    assign release_own = !req_q[last_q];
    assign preempt     = (LIMIT != 8'd0) && (hold_q >= LIMIT) && others && as_idle_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        grnt_d  = grnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWNED;
                    last_d  = win;
                    owner_d = win;
                    grnt_d  = ~(ONE_HOT0 << win);
                    hold_d  = 8'd0;
                end
            end
            OWNED: begin
                if (release_own || preempt) begin
                    if (found) begin
                        last_d  = win;
                        owner_d = win;
                        grnt_d  = ~(ONE_HOT0 << win);
                        hold_d  = 8'd0;
                    end else begin
                        state_d = IDLE;
                        grnt_d  = '1;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grnt_d  = '1;
            end
        endcase
    end

    assign busGrnt_   = grnt_q;
    assign busOwner   = owner_q;
    assign ownerValid = (state_q == OWNED);

endmodule
